if_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the IF PC logic and the instruction-side SRAM-like bus (req / addr_ok / data_ok).
- Generates the fetch PC (reset vector, sequential +4, branch or exception redirect) and keeps one request outstanding at a time.
- Discards responses that belong to redirected fetches, and presents one instruction at a time to ID under the pipeline stall.

---
 rtl/if_fetch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding request at a time on the I-side bus.
// Optional macro IF_ADEL_CHECK_EN enables the misaligned-PC address-error path.
module if_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [31:0]       inst_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_adel_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              drop_q, drop_d;
  logic              redir_pend_q, redir_pend_d;
  logic              req_en_q;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
`ifdef IF_ADEL_CHECK_EN
  logic              if_adel_q, if_adel_d;
  logic              misaligned;
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
`endif

  logic              redirect;
  logic [ADDR_W-1:0] redir_pc;

  assign redirect = flush_i | branch_i;
  assign redir_pc = flush_i ? flush_pc_i : branch_pc_i;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    drop_d       = drop_q;
    redir_pend_d = redir_pend_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
`ifdef IF_ADEL_CHECK_EN
    if_adel_d    = if_adel_q;
`endif
    case (state_q)
      StReq: begin
        // No request is on the bus yet in the first cycle after reset.
        if (!req_en_q) begin
          if (redirect) fetch_pc_d = redir_pc;
        end else
`ifdef IF_ADEL_CHECK_EN
        if (misaligned) begin
          state_d    = StHold;
          if_valid_d = 1'b1;
          if_pc_d    = fetch_pc_q;
          if_inst_d  = 32'h0;
          if_adel_d  = 1'b1;
        end else
`endif
        begin
          // The held request must complete; its response is dropped later.
          if (redirect) begin
            drop_d    = 1'b1;
            pend_pc_d = redir_pc;
          end
          if (inst_addr_ok_i) state_d = StWait;
        end
      end
      StWait: begin
        if (inst_data_ok_i) begin
          if (drop_q || redirect) begin
            drop_d     = 1'b0;
            fetch_pc_d = redirect ? redir_pc : pend_pc_q;
            state_d    = StReq;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = fetch_pc_q;
            if_inst_d  = inst_rdata_i;
            state_d    = StHold;
          end
        end else if (redirect) begin
          drop_d    = 1'b1;
          pend_pc_d = redir_pc;
        end
      end
      StHold: begin
`ifdef IF_ADEL_CHECK_EN
        if (if_adel_q) begin
          if (flush_i) begin
            if_valid_d = 1'b0;
            if_adel_d  = 1'b0;
            fetch_pc_d = flush_pc_i;
            state_d    = StReq;
          end else if (!stall_i) begin
            if_valid_d = 1'b0;
            state_d    = StIdle;
          end
        end else
`endif
        if (flush_i) begin
          if_valid_d   = 1'b0;
          redir_pend_d = 1'b0;
          fetch_pc_d   = flush_pc_i;
          state_d      = StReq;
        end else if (!stall_i) begin
          // Presented instruction is the delay slot, so a branch still accepts it.
          if_valid_d   = 1'b0;
          redir_pend_d = 1'b0;
          state_d      = StReq;
          if (branch_i)          fetch_pc_d = branch_pc_i;
          else if (redir_pend_q) fetch_pc_d = pend_pc_q;
          else                   fetch_pc_d = if_pc_q + ADDR_W'(4);
        end else if (branch_i) begin
          pend_pc_d    = branch_pc_i;
          redir_pend_d = 1'b1;
        end
      end
      StIdle: begin
        if (flush_i) begin
          fetch_pc_d = flush_pc_i;
          state_d    = StReq;
`ifdef IF_ADEL_CHECK_EN
          if_adel_d  = 1'b0;
`endif
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StReq;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= '0;
      drop_q       <= 1'b0;
      redir_pend_q <= 1'b0;
      req_en_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_inst_q    <= '0;
`ifdef IF_ADEL_CHECK_EN
      if_adel_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      drop_q       <= drop_d;
      redir_pend_q <= redir_pend_d;
      req_en_q     <= 1'b1;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
`ifdef IF_ADEL_CHECK_EN
      if_adel_q    <= if_adel_d;
`endif
    end
  end

`ifdef IF_ADEL_CHECK_EN
  assign inst_req_o = req_en_q & (state_q == StReq) & ~misaligned;
  assign if_adel_o  = if_adel_q;
`else
  assign inst_req_o = req_en_q & (state_q == StReq);
  assign if_adel_o  = 1'b0;
`endif
  assign inst_addr_o = fetch_pc_q;
  assign busy_o      = (state_q == StWait);
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed steps then randomized bus/pipeline traffic,
// checked against a next-presented-PC reference model.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RstPc = 32'hBFC0_0000;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, branch_i;
  logic [31:0] flush_pc_i, branch_pc_i;
  logic        inst_req_o, inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_addr_o, inst_rdata_i;
  logic        if_valid_o, if_adel_o, busy_o;
  logic [31:0] if_pc_o, if_inst_o;

  if_fetch_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .branch_i       (branch_i),
    .branch_pc_i    (branch_pc_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o),
    .if_adel_o      (if_adel_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: PC expected at the next presentation.
  logic [31:0] exp_pc, pres_pc;
  logic        redir_in_pres, expect_zero, hold_expect;
  // Bus responder state.
  logic        out;
  logic [31:0] out_addr;
  int          dcnt, dgap, ok_lat, req_wait;
  logic        rand_bus;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == RstPc) return 32'h2408_0001;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
`ifdef IF_ADEL_CHECK_EN
    if (a[1:0] != 2'b00) return 32'h0;
`endif
    return mem(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic st, input logic fl, input logic [31:0] fpc,
                       input logic br, input logic [31:0] bpc);
    logic        v, pr, pok, dok;
    logic [31:0] pa;
    stall_i        = st;
    flush_i        = fl;
    flush_pc_i     = fpc;
    branch_i       = br;
    branch_pc_i    = bpc;
    inst_addr_ok_i = inst_req_o && !out && (req_wait >= ok_lat);
    inst_data_ok_i = out && (dcnt >= dgap);
    inst_rdata_i   = inst_data_ok_i ? mem(out_addr) : $urandom;
    v   = if_valid_o;
    pr  = inst_req_o;
    pok = inst_addr_ok_i;
    dok = inst_data_ok_i;
    pa  = inst_addr_o;
    expect_zero = 1'b0;
    hold_expect = 1'b0;
    if (v) begin
      if (fl) begin
        exp_pc = fpc; redir_in_pres = 1'b0; expect_zero = 1'b1;
      end else if (st) begin
        hold_expect = 1'b1;
        if (br) begin exp_pc = bpc; redir_in_pres = 1'b1; end
      end else begin
        if (br) exp_pc = bpc;
        else if (!redir_in_pres) exp_pc = exp_pc + 32'd4;
        redir_in_pres = 1'b0;
        expect_zero = 1'b1;
      end
    end else if (fl || br) begin
      exp_pc = fl ? fpc : bpc;
    end
    if (dok) out = 1'b0;
    else if (out) dcnt++;
    if (pok) begin
      out = 1'b1; out_addr = pa; dcnt = 0; req_wait = 0;
      if (rand_bus) begin
        dgap   = int'($urandom_range(0, 3));
        ok_lat = int'($urandom_range(0, 3));
      end
    end else if (pr) begin
      req_wait++;
    end
    @(posedge clk_i); #1;
    chk_b("busy", busy_o, out);
    if (out) chk_b("req_while_busy", inst_req_o, 1'b0);
    if (pr && !pok) begin
      chk_b("req_hold", inst_req_o, 1'b1);
      chk("addr_hold", inst_addr_o, pa);
    end
    if (expect_zero) chk_b("valid_drop", if_valid_o, 1'b0);
    if (hold_expect) begin
      chk_b("hold_valid", if_valid_o, 1'b1);
      chk("hold_pc", if_pc_o, pres_pc);
      chk("hold_inst", if_inst_o, exp_inst(pres_pc));
    end
    if (if_valid_o && !v) begin
      chk("pres_pc", if_pc_o, exp_pc);
      chk("pres_inst", if_inst_o, exp_inst(exp_pc));
      pres_pc = exp_pc;
      redir_in_pres = 1'b0;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wait_valid(input int lim, input string tag);
    int n = 0;
    while (!if_valid_o && n < lim) begin idle(); n++; end
    chk_b(tag, if_valid_o, 1'b1);
  endtask

  task automatic wait_req(input int lim, input string tag);
    int n = 0;
    while (!inst_req_o && n < lim) begin idle(); n++; end
    chk_b(tag, inst_req_o, 1'b1);
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_i = 1'b0;
    flush_pc_i = '0; branch_pc_i = '0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    out = 1'b0; out_addr = '0; dcnt = 0; dgap = 0; ok_lat = 0; req_wait = 0;
    rand_bus = 1'b0; redir_in_pres = 1'b0; exp_pc = RstPc; pres_pc = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_b("rst_req", inst_req_o, 1'b0);
    chk("rst_addr", inst_addr_o, RstPc);
    chk_b("rst_valid", if_valid_o, 1'b0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_inst", if_inst_o, 32'h0);
    chk_b("rst_adel", if_adel_o, 1'b0);
    chk_b("rst_busy", busy_o, 1'b0);
    rst_i = 1'b1;

    // First fetch from the reset vector.
    wait_req(4, "first_req");
    chk("first_addr", inst_addr_o, RstPc);
    wait_valid(10, "first_valid");
    chk("first_pc", if_pc_o, RstPc);
    chk("first_inst", if_inst_o, 32'h2408_0001);
    idle();
    chk_b("seq_req", inst_req_o, 1'b1);
    chk("seq_addr", inst_addr_o, 32'hBFC0_0004);
    idle();
    idle();
    chk_b("latency3", if_valid_o, 1'b1);

    // Five stalled cycles in HOLD.
    repeat (5) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_b("stall_noreq", inst_req_o, 1'b0);
    end
    idle();
    chk_b("post_stall_req", inst_req_o, 1'b1);
    chk("post_stall_addr", inst_addr_o, 32'hBFC0_0008);

    // Branch while waiting for BFC00008.
    dgap = 2;
    idle();
    chk_b("wait_busy", busy_o, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0100);
    wait_req(8, "br_req");
    chk("br_addr", inst_addr_o, 32'hBFC0_0100);
    dgap = 0;
    wait_valid(8, "br_valid");
    chk("br_pc", if_pc_o, 32'hBFC0_0100);

    // Flush and branch together in HOLD: flush wins, slot is dropped.
    cycle(1'b0, 1'b1, 32'hBFC0_0380, 1'b1, 32'hBFC0_0200);
    chk_b("fl_valid", if_valid_o, 1'b0);
    chk_b("fl_req", inst_req_o, 1'b1);
    chk("fl_addr", inst_addr_o, 32'hBFC0_0380);
    wait_valid(8, "fl_pres");
    chk("fl_pc", if_pc_o, 32'hBFC0_0380);

    // addr_ok delayed by four cycles.
    ok_lat = 4;
    idle();
    repeat (4) begin
      idle();
      chk_b("slow_req", inst_req_o, 1'b1);
      chk("slow_addr", inst_addr_o, 32'hBFC0_0384);
      chk_b("slow_busy", busy_o, 1'b0);
    end
    idle();
    chk_b("slow_busy_on", busy_o, 1'b1);
    ok_lat = 0;
    wait_valid(8, "slow_pres");

    // Randomized traffic.
    rand_bus = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic st, fl, br;
      logic [31:0] fpc, bpc;
      st  = ($urandom_range(0, 9) < 3);
      fl  = ($urandom_range(0, 99) < 3);
      br  = ($urandom_range(0, 99) < 6);
      fpc = RstPc + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      bpc = RstPc + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cycle(st, fl, fpc, br, bpc);
    end

`ifdef IF_ADEL_CHECK_EN
    // Misaligned branch target raises the address-error slot.
    wait_valid(50, "adel_pre");
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0102);
    wait_valid(10, "adel_valid");
    chk_b("adel_flag", if_adel_o, 1'b1);
    chk("adel_pc", if_pc_o, 32'hBFC0_0102);
    chk_b("adel_noreq", inst_req_o, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
